// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity-mode codes and parity check for uart_rx_mp
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam int MAX_DATA = 9;
  function automatic logic parity_err(input logic [MAX_DATA-1:0] d, input logic p, input logic [1:0] mode);
    return (^d ^ p) ^ (mode == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop line synchronizer, per-tick sample history and start-edge detect (UART_RX_MAJORITY_VOTE_EN adds 2-of-3 voting)
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic tick,
  output logic smp,
  output logic start_edge
);
  logic [1:0] sync_q;
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx};
      if (tick) prev <= sync_q[1];
    end
  assign start_edge = tick & prev & ~sync_q[1];
`ifdef UART_RX_MAJORITY_VOTE_EN
  // vote over the ticks at nominal-1, nominal and nominal+1 (the current one)
  logic prev2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev2 <= 1'b1;
    else if (tick) prev2 <= prev;
  assign smp = (sync_q[1] & prev) | (sync_q[1] & prev2) | (prev & prev2);
`else
  assign smp = sync_q[1];
`endif
endmodule

// File: rtl/uart_rx_mp.sv
// uart_rx_mp: parametrised oversampling UART receiver; UART_RX_MAJORITY_VOTE_EN moves each decision one tick later for 2-of-3 voting
module uart_rx_mp
  import uart_pkg::*;
#(
  parameter int OVS    = 16,
  parameter int N_DATA = 8,
  parameter int M_STOP = 1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_rx,
  input  logic              i_valid,
  input  logic [1:0]        i_parity_mode,
  output logic [N_DATA-1:0] o_data,
  output logic              o_rx_done,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_busy
);
  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(N_DATA + 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [TW-1:0] START_PT = TW'(OVS / 2);
`else
  localparam logic [TW-1:0] START_PT = TW'(OVS / 2 - 1);
`endif
  state_t state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [N_DATA-1:0] sr, sr_n;
  logic [1:0] mode, mode_n;
  logic perr, perr_n, ferr, ferr_n, fin, at_pt, last_data, last_stop, smp, start_edge;
  uart_rx_sync u_sync (
    .clk       (i_clock),
    .rst_n     (i_reset_n),
    .rx        (i_rx),
    .tick      (i_valid),
    .smp       (smp),
    .start_edge(start_edge)
  );
  // first sample is half a bit after the edge, every later one a full bit after the previous
  assign at_pt     = tcnt == (state == START ? START_PT : TW'(OVS - 1));
  assign last_data = bcnt == BW'(N_DATA - 1);
  assign last_stop = bcnt == BW'(M_STOP - 1);
  assign o_busy    = state != IDLE;
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bcnt_n  = bcnt;
    sr_n    = sr;
    mode_n  = mode;
    perr_n  = perr;
    ferr_n  = ferr;
    fin     = 1'b0;
    if (i_valid) begin
      tcnt_n = at_pt ? '0 : tcnt + 1'b1;
      case (state)
        IDLE: begin
          tcnt_n = '0;
          if (start_edge) begin
            state_n = START;
            mode_n  = i_parity_mode;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
          end
        end
        START:
          if (at_pt) state_n = smp ? IDLE : DATA;
        DATA:
          if (at_pt) begin
            sr_n   = {smp, sr[N_DATA-1:1]};
            bcnt_n = last_data ? '0 : bcnt + 1'b1;
            if (last_data) state_n = (mode == PAR_EVEN || mode == PAR_ODD) ? PARITY : STOP;
          end
        PARITY:
          if (at_pt) begin
            perr_n  = parity_err(MAX_DATA'(sr), smp, mode);
            state_n = STOP;
          end
        STOP:
          if (at_pt) begin
            ferr_n = ferr | ~smp;
            bcnt_n = last_stop ? '0 : bcnt + 1'b1;
            if (last_stop) begin
              state_n = IDLE;
              fin     = 1'b1;
            end
          end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state        <= IDLE;
      tcnt         <= '0;
      bcnt         <= '0;
      sr           <= '0;
      mode         <= PAR_NONE;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      o_data       <= '0;
      o_rx_done    <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state     <= state_n;
      tcnt      <= tcnt_n;
      bcnt      <= bcnt_n;
      sr        <= sr_n;
      mode      <= mode_n;
      perr      <= perr_n;
      ferr      <= ferr_n;
      o_rx_done <= fin;
      if (fin) begin
        o_data       <= sr;
        o_parity_err <= perr;
        o_frame_err  <= ferr_n;
      end
    end
endmodule

// File: tb/tb_uart_rx_mp.sv
// tb_uart_rx_mp: scoreboard bench for uart_rx_mp (8N1 with parity modes, and 7-bit/2-stop instance)
module tb_uart_rx_mp;
  localparam int OVS = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int MV = 1;
`else
  localparam int MV = 0;
`endif
  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    int         t;
  } item_t;
  logic clk = 0, rst_n = 0, valid = 0, rx8 = 1, rx7 = 1;
  logic [1:0] pmode = 2'b00, div = 2'b00;
  logic [7:0] data8;
  logic [6:0] data7;
  logic done8, perr8, ferr8, busy8, done7, perr7, ferr7, busy7;
  int ntick = 0, checks = 0, errors = 0;
  item_t q8[$], q7[$];

  always #5 clk = ~clk;
  always @(negedge clk) begin
    div   <= div + 2'd1;
    valid <= (div == 2'd3);
  end
  always @(posedge clk) if (valid) ntick <= ntick + 1;

  uart_rx_mp #(.OVS(OVS), .N_DATA(8), .M_STOP(1)) dut8 (
    .i_clock(clk), .i_reset_n(rst_n), .i_rx(rx8), .i_valid(valid), .i_parity_mode(pmode),
    .o_data(data8), .o_rx_done(done8), .o_parity_err(perr8), .o_frame_err(ferr8), .o_busy(busy8));
  uart_rx_mp #(.OVS(OVS), .N_DATA(7), .M_STOP(2)) dut7 (
    .i_clock(clk), .i_reset_n(rst_n), .i_rx(rx7), .i_valid(valid), .i_parity_mode(2'b00),
    .o_data(data7), .o_rx_done(done7), .o_parity_err(perr7), .o_frame_err(ferr7), .o_busy(busy7));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wt();
    @(posedge clk);
    while (!valid) @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit sel, input logic v, input int n);
    if (sel) rx7 = v;
    else rx8 = v;
    repeat (n) wt();
  endtask

  task automatic idle(input int n);
    rx8 = 1'b1;
    rx7 = 1'b1;
    repeat (n) wt();
  endtask

  // the edge tick is the first tick after the start bit is driven
  task automatic send(input bit sel, input logic [8:0] d, input int nb, input int np, input logic pb,
                      input logic [1:0] st, input int ns, input logic [8:0] ed, input logic epe,
                      input logic efe, input int gb);
    item_t it;
    it.d  = ed;
    it.pe = epe;
    it.fe = efe;
    it.t  = ntick + 1 + OVS / 2 + OVS * (nb + np + ns) + MV;
    if (sel) q7.push_back(it);
    else q8.push_back(it);
    drv(sel, 1'b0, OVS);
    for (int i = 0; i < nb; i++)
      if (i == gb) begin
        drv(sel, d[i], OVS / 2);
        drv(sel, !d[i], 1);
        drv(sel, d[i], OVS / 2 - 1);
      end else drv(sel, d[i], OVS);
    if (np != 0) drv(sel, pb, OVS);
    for (int i = 0; i < ns; i++) drv(sel, st[i], OVS);
  endtask

  initial forever begin
    @(negedge clk);
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done8: got pulse at tick %0d, expected none", ntick);
      end else begin
        item_t it;
        it = q8.pop_front();
        chk("data8", data8, it.d);
        chk("perr8", perr8, it.pe);
        chk("ferr8", ferr8, it.fe);
        chk("latency8", ntick, it.t);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done7 === 1'b1) begin
      if (q7.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done7: got pulse at tick %0d, expected none", ntick);
      end else begin
        item_t it;
        it = q7.pop_front();
        chk("data7", data7, it.d);
        chk("perr7", perr7, it.pe);
        chk("ferr7", ferr7, it.fe);
        chk("latency7", ntick, it.t);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_data", data8, 0);
    chk("rst_done", done8, 0);
    chk("rst_perr", perr8, 0);
    chk("rst_ferr", ferr8, 0);
    chk("rst_busy", busy8, 0);
    idle(20);
    send(0, 9'hA5, 8, 0, 1'b0, 2'b11, 1, 9'hA5, 1'b0, 1'b0, -1);
    idle(4);
    chk("busy_after", busy8, 0);
    pmode = 2'b01;
    send(0, 9'h07, 8, 1, 1'b1, 2'b11, 1, 9'h07, 1'b0, 1'b0, -1);
    idle(4);
    send(0, 9'h07, 8, 1, 1'b0, 2'b11, 1, 9'h07, 1'b1, 1'b0, -1);
    idle(4);
    pmode = 2'b10;
    send(0, 9'h07, 8, 1, 1'b0, 2'b11, 1, 9'h07, 1'b0, 1'b0, -1);
    idle(4);
    pmode = 2'b00;
    send(0, 9'h3C, 8, 0, 1'b0, 2'b00, 1, 9'h3C, 1'b0, 1'b1, -1);
    idle(20);
    send(0, 9'h55, 8, 0, 1'b0, 2'b11, 1, 9'h55, 1'b0, 1'b0, -1);
    idle(20);
    drv(0, 1'b0, 4);
    idle(30);
    chk("fs_data", data8, 8'h55);
    chk("fs_ferr", ferr8, 0);
    chk("fs_busy", busy8, 0);
    drv(0, 1'b0, OVS);
    drv(0, 1'b1, 3 * OVS + OVS / 2);
    chk("busy_pre_rst", busy8, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_data", data8, 0);
    chk("mid_rst_done", done8, 0);
    chk("mid_rst_perr", perr8, 0);
    chk("mid_rst_ferr", ferr8, 0);
    chk("mid_rst_busy", busy8, 0);
    #5 rst_n = 1'b1;
    drv(0, 1'b1, 5 * OVS);
    idle(20);
    send(0, 9'h81, 8, 0, 1'b0, 2'b11, 1, 9'h81, 1'b0, 1'b0, -1);
    idle(20);
    send(0, 9'h12, 8, 0, 1'b0, 2'b11, 1, 9'h12, 1'b0, 1'b0, -1);
    send(0, 9'h34, 8, 0, 1'b0, 2'b11, 1, 9'h34, 1'b0, 1'b0, -1);
    idle(20);
    send(1, 9'h33, 7, 0, 1'b0, 2'b11, 2, 9'h33, 1'b0, 1'b0, -1);
    idle(20);
    send(1, 9'h5A, 7, 0, 1'b0, 2'b01, 2, 9'h5A, 1'b0, 1'b1, -1);
    idle(20);
`ifdef UART_RX_MAJORITY_VOTE_EN
    send(0, 9'hA5, 8, 0, 1'b0, 2'b11, 1, 9'hA5, 1'b0, 1'b0, 2);
    idle(20);
`endif
    chk("pending8", q8.size(), 0);
    chk("pending7", q7.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
